// File: rtl/router_scheduler.sv
// Buffer-to-PE router scheduler: walks depthwise (tile/ky/kx) or pointwise (col/rpsel)
// address sequences per block, ping-pongs the input bank and reports block/job completion.
module router_scheduler #(
  parameter int POX    = 16,
  parameter int POY    = 3,
  parameter int BUFW   = 48,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dw_mode,
  input  logic [7:0]  nblk,
  input  logic [3:0]  tiles,
  input  logic        buf_ready,
  input  logic        pe_stall,
  output logic        busy,
  output logic        done,
  output logic        dw_comp,
  output logic [1:0]  bank,
  output logic [1:0]  row,
  output logic [27:0] col,
  output logic [1:0]  rpsel,
  output logic        blkend,
  output logic        dwpe_ena
);

  typedef enum logic [2:0] {IDLE, WAIT_BUF, DW_RUN, PW_RUN, BLK_END, DONE} state_t;

  localparam logic [27:0] COL_STEP = 28'(POX * STRIDE);
  localparam logic [27:0] CMAX     = 28'(BUFW - 1);
  localparam logic [1:0]  KMAX     = 2'(KSIZE - 1);
  localparam logic [1:0]  PMAX     = 2'(POY - 1);

  state_t      state;
  logic [7:0]  nblk_q;
  logic [7:0]  blk_cnt;
  logic [3:0]  tile_max;
  logic [3:0]  t_cnt;
  logic [1:0]  kx_cnt;

  logic        dw_last, pw_last;
  logic [3:0]  t_nxt;
  logic [1:0]  ky_nxt, kx_nxt, p_nxt;
  logic [27:0] c_nxt;
  logic [7:0]  blk_inc;

  // row doubles as the ky counter and col/rpsel as the pointwise counters,
  // so holding the outputs under stall also holds the loop position.
  always_comb begin
    dw_last = (t_cnt == tile_max) && (row == KMAX) && (kx_cnt == KMAX);
    pw_last = (col == CMAX) && (rpsel == PMAX);
    t_nxt   = t_cnt;
    ky_nxt  = row;
    kx_nxt  = kx_cnt + 2'd1;
    if (kx_cnt == KMAX) begin
      kx_nxt = 2'd0;
      if (row == KMAX) begin
        ky_nxt = 2'd0;
        t_nxt  = t_cnt + 4'd1;
      end else begin
        ky_nxt = row + 2'd1;
      end
    end
    p_nxt = rpsel + 2'd1;
    c_nxt = col;
    if (rpsel == PMAX) begin
      p_nxt = 2'd0;
      c_nxt = col + 28'd1;
    end
    blk_inc = blk_cnt + 8'd1;
  end

  // pe_stall throttles issue of the next step: the visible step stays put
  // with dwpe_ena low, and the following step goes out once the stall clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      nblk_q   <= '0;
      blk_cnt  <= '0;
      tile_max <= '0;
      t_cnt    <= '0;
      kx_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dw_comp  <= 1'b0;
      bank     <= '0;
      row      <= '0;
      col      <= '0;
      rpsel    <= '0;
      blkend   <= 1'b0;
      dwpe_ena <= 1'b0;
    end else begin
      done     <= 1'b0;
      blkend   <= 1'b0;
      dwpe_ena <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dw_comp  <= dw_mode;
            nblk_q   <= nblk;
            tile_max <= (tiles == 4'd0) ? 4'd0 : tiles - 4'd1;
            blk_cnt  <= '0;
            busy     <= 1'b1;
            if (nblk == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_BUF;
            end
          end
        end
        WAIT_BUF: begin
          if (buf_ready) begin
            t_cnt    <= '0;
            kx_cnt   <= '0;
            row      <= '0;
            col      <= '0;
            rpsel    <= '0;
            dwpe_ena <= 1'b1;
            state    <= dw_comp ? DW_RUN : PW_RUN;
          end
        end
        DW_RUN: begin
          if (!pe_stall) begin
            if (dw_last) begin
              state  <= BLK_END;
              blkend <= 1'b1;
            end else begin
              t_cnt    <= t_nxt;
              kx_cnt   <= kx_nxt;
              row      <= ky_nxt;
              col      <= 28'(t_nxt) * COL_STEP + 28'(kx_nxt);
              dwpe_ena <= 1'b1;
            end
          end
        end
        PW_RUN: begin
          if (!pe_stall) begin
            if (pw_last) begin
              state  <= BLK_END;
              blkend <= 1'b1;
            end else begin
              col      <= c_nxt;
              rpsel    <= p_nxt;
              dwpe_ena <= 1'b1;
            end
          end
        end
        BLK_END: begin
          bank    <= {1'b0, ~bank[0]};
          blk_cnt <= blk_inc;
          if (blk_inc == nblk_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= WAIT_BUF;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_scheduler.sv
// Scoreboard bench for router_scheduler: drivers queue expected events, a negedge
// monitor pops and compares every step/blkend/done the DUT presents.
module tb_router_scheduler;

  localparam int W = 36;
  localparam logic [1:0] K_STEP = 2'd1;
  localparam logic [1:0] K_BLK  = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dw_mode = 1'b0;
  logic [7:0]  nblk = '0;
  logic [3:0]  tiles = '0;
  logic        buf_ready = 1'b0;
  logic        pe_stall = 1'b0;
  logic        busy, done, dw_comp, blkend, dwpe_ena;
  logic [1:0]  bank, row, rpsel;
  logic [27:0] col;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ena_cnt, blk_seen, done_seen, first_ena_cyc, last_blk_cyc, last_done_cyc;

  router_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dw_mode(dw_mode), .nblk(nblk),
    .tiles(tiles), .buf_ready(buf_ready), .pe_stall(pe_stall), .busy(busy),
    .done(done), .dw_comp(dw_comp), .bank(bank), .row(row), .col(col),
    .rpsel(rpsel), .blkend(blkend), .dwpe_ena(dwpe_ena)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mk(input logic [1:0] k, input logic [1:0] r,
                                      input logic [27:0] c, input logic [1:0] p,
                                      input logic [1:0] b);
    return {k, r, c, p, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every strobe the DUT presents is matched against the queue head
  always @(negedge clk) begin
    int nev;
    logic [W-1:0] act, e;
    if (rst_n) begin
      if (dwpe_ena) begin
        ena_cnt++;
        if (first_ena_cyc < 0) first_ena_cyc = cyc;
      end
      if (blkend) begin blk_seen++;  last_blk_cyc = cyc;  end
      if (done)   begin done_seen++; last_done_cyc = cyc; end
      nev = int'(dwpe_ena) + int'(blkend) + int'(done);
      if (nev > 1) chk("one_event_per_cycle", 64'(nev), 64'd1);
      else if (nev == 1) begin
        if (dwpe_ena)    act = mk(K_STEP, row, col, rpsel, bank);
        else if (blkend) act = mk(K_BLK, 2'd0, 28'd0, 2'd0, bank);
        else             act = mk(K_DONE, 2'd0, 28'd0, 2'd0, bank);
        if (exp_q.size() == 0) chk("unexpected_event", 64'(act), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("event", 64'(act), 64'(e));
        end
      end
    end
  end

  task automatic clear_stats();
    ena_cnt = 0; blk_seen = 0; done_seen = 0;
    first_ena_cyc = -1; last_blk_cyc = -1; last_done_cyc = -1;
  endtask

  task automatic push_dw_block(input int nt, input logic [1:0] b);
    for (int t = 0; t < nt; t++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          exp_q.push_back(mk(K_STEP, 2'(ky), 28'(t * 32 + kx), 2'd0, b));
    exp_q.push_back(mk(K_BLK, 2'd0, 28'd0, 2'd0, b));
  endtask

  task automatic push_pw_block(input logic [1:0] b);
    for (int c = 0; c < 48; c++)
      for (int p = 0; p < 3; p++)
        exp_q.push_back(mk(K_STEP, 2'd0, 28'(c), 2'(p), b));
    exp_q.push_back(mk(K_BLK, 2'd0, 28'd0, 2'd0, b));
  endtask

  task automatic push_done(input logic [1:0] b);
    exp_q.push_back(mk(K_DONE, 2'd0, 28'd0, 2'd0, b));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pe_stall = 1'b0;
    exp_q.delete();
    clear_stats();
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, dw_comp, bank, row, col, rpsel, blkend, dwpe_ena}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // config is scrambled after the start cycle to show it is only sampled there
  task automatic pulse_start(input logic m, input logic [7:0] nb, input logic [3:0] tl,
                             output int scyc);
    @(posedge clk); #1;
    start = 1'b1; dw_mode = m; nblk = nb; tiles = tl; scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; dw_mode = 1'($urandom_range(0, 1));
    nblk = 8'($urandom_range(0, 255)); tiles = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < budget);
    chk({name, "_done_timeout"}, 64'(n < budget), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int scyc, rcyc, n;
    clear_stats();

    // depthwise, 1 block, 2 tiles
    do_reset();
    buf_ready = 1'b1;
    push_dw_block(2, 2'd0); push_done(2'd1);
    pulse_start(1'b1, 8'd1, 4'd2, scyc);
    wait_done(200, "dw2");
    chk("dw2_ena_cnt", 64'(ena_cnt), 64'd18);
    chk("dw2_done_after_blkend", 64'(last_done_cyc - last_blk_cyc), 64'd1);
    chk("dw2_idle", 64'({busy, bank}), 64'({1'b0, 2'd1}));
    chk("dw2_queue_empty", 64'(exp_q.size()), 64'd0);

    // pointwise, 2 blocks
    do_reset();
    buf_ready = 1'b1;
    push_pw_block(2'd0); push_pw_block(2'd1); push_done(2'd0);
    pulse_start(1'b0, 8'd2, 4'd0, scyc);
    wait_done(500, "pw2");
    chk("pw2_ena_cnt", 64'(ena_cnt), 64'd288);
    chk("pw2_blkend_cnt", 64'(blk_seen), 64'd2);
    chk("pw2_done_cnt", 64'(done_seen), 64'd1);
    chk("pw2_queue_empty", 64'(exp_q.size()), 64'd0);

    // stall 3 cycles at depthwise step (1,1); tiles=0 behaves as 1
    do_reset();
    buf_ready = 1'b1;
    push_dw_block(1, 2'd0); push_done(2'd1);
    pulse_start(1'b1, 8'd1, 4'd0, scyc);
    n = 0;
    do begin @(negedge clk); n++; end while (!(dwpe_ena && row == 2'd1 && col == 28'd0) && n < 50);
    chk("stall_reach_step", 64'(n < 50), 64'd1);
    pe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({dwpe_ena, row, col, rpsel}), 64'({1'b0, 2'd1, 28'd0, 2'd0}));
    end
    pe_stall = 1'b0;
    @(negedge clk);
    chk("stall_reissue", 64'({dwpe_ena, row, col}), 64'({1'b1, 2'd1, 28'd1}));
    wait_done(100, "stall");
    chk("stall_run_len", 64'(last_blk_cyc - first_ena_cyc), 64'd12);
    chk("stall_ena_cnt", 64'(ena_cnt), 64'd9);
    chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // buffer not ready for 10 cycles after start
    do_reset();
    buf_ready = 1'b0;
    push_dw_block(1, 2'd0); push_done(2'd1);
    pulse_start(1'b1, 8'd1, 4'd1, scyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0 || i == 9) chk("wait_buf_busy", 64'({busy, dwpe_ena}), 64'({1'b1, 1'b0}));
    end
    @(posedge clk); #1 buf_ready = 1'b1; rcyc = cyc;
    wait_done(100, "bufwait");
    chk("bufwait_first_step", 64'(first_ena_cyc - rcyc), 64'd1);
    chk("bufwait_ena_cnt", 64'(ena_cnt), 64'd9);

    // nblk = 0: done only, no steps or block ends
    do_reset();
    buf_ready = 1'b1;
    push_done(2'd0);
    pulse_start(1'b1, 8'd0, 4'd3, scyc);
    wait_done(10, "nblk0");
    chk("nblk0_done_latency", 64'((last_done_cyc - scyc) >= 1 && (last_done_cyc - scyc) <= 2), 64'd1);
    chk("nblk0_no_activity", 64'({ena_cnt[15:0], blk_seen[15:0]}), 64'd0);

    // second start during a busy job is ignored
    do_reset();
    buf_ready = 1'b1;
    push_dw_block(1, 2'd0); push_done(2'd1);
    pulse_start(1'b1, 8'd1, 4'd1, scyc);
    repeat (3) @(negedge clk);
    pulse_start(1'b0, 8'd5, 4'd2, scyc);
    wait_done(100, "restart");
    repeat (5) @(negedge clk);
    chk("restart_ignored", 64'({busy, done_seen[7:0], ena_cnt[7:0]}), 64'({1'b0, 8'd1, 8'd9}));

    // asynchronous reset mid depthwise run, then a fresh job
    do_reset();
    buf_ready = 1'b1;
    push_dw_block(2, 2'd0); push_done(2'd1);
    pulse_start(1'b1, 8'd1, 4'd2, scyc);
    n = 0;
    do begin @(negedge clk); n++; end while (ena_cnt < 5 && n < 50);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 64'({busy, done, dw_comp, bank, row, col, rpsel, blkend, dwpe_ena}), 64'd0);
    exp_q.delete();
    clear_stats();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", 64'({busy, done_seen[7:0], blk_seen[7:0]}), 64'd0);
    push_dw_block(1, 2'd0); push_done(2'd1);
    pulse_start(1'b1, 8'd1, 4'd1, scyc);
    wait_done(100, "after_abort");
    chk("after_abort_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router_scheduler.md
ROUTER_SCHEDULER -- requirements
Module: router_scheduler

Interface
REQ-001 Parameters SHALL be: POX, 16, output pixels per row. POY, 3, output rows. BUFW, 48, buffer width in pixels. KSIZE, 3, depthwise kernel size. STRIDE, 2, depthwise stride.
REQ-002 Ports SHALL be: clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle job request, honoured only in IDLE.
REQ-005 dw_mode  input  1  job type: 1 = depthwise, 0 = pointwise; captured at start.
REQ-006 nblk  input  8  number of blocks in the job; captured at start.
REQ-007 tiles  input  4  column tiles per depthwise block; captured at start; 0 is treated as 1.
REQ-008 buf_ready  input  1  current input buffer bank is filled.
REQ-009 pe_stall  input  1  downstream PE cannot accept data.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at job end.
REQ-012 dw_comp  output  1  registered copy of captured dw_mode.
REQ-013 bank  output  2  active buffer bank.
REQ-014 row  output  2  kernel row select (depthwise mode).
REQ-015 col  output  28  buffer column address.
REQ-016 rpsel  output  2  row-pixel select (pointwise mode).
REQ-017 blkend  output  1  one-cycle end-of-block pulse.
REQ-018 dwpe_ena  output  1  data valid strobe to the PE array.

Function
REQ-019 The block SHALL implement the FSM states IDLE, WAIT_BUF, DW_RUN, PW_RUN, BLK_END and DONE. All outputs SHALL be registered.
REQ-020 IDLE with start=1: the block SHALL capture the config, clear the block counter, and move to WAIT_BUF on the next edge. If nblk=0, it SHALL move to DONE instead.
REQ-021 WAIT_BUF with buf_ready=1: the block SHALL move to DW_RUN if dw_comp=1, else to PW_RUN, with all run counters at 0.
REQ-022 DW_RUN loop order, outermost first: tile t 0..tiles-1, then ky 0..KSIZE-1, then kx 0..KSIZE-1.
REQ-023 DW_RUN outputs per step: row=ky, col=t*POX*STRIDE+kx, rpsel=0, dwpe_ena=1. Each block SHALL take tiles*KSIZE*KSIZE unstalled cycles.
REQ-024 PW_RUN loop order: col c 0..BUFW-1 outer, rpsel 0..POY-1 inner. Outputs: row=0, col=c, dwpe_ena=1. Each block SHALL take BUFW*POY unstalled cycles.
REQ-025 After the final step of a run, the block SHALL enter BLK_END for exactly one cycle with blkend=1 and dwpe_ena=0.
REQ-026 On leaving BLK_END, bank SHALL toggle 0<->1 and the block counter SHALL increment. If the counter equals nblk, the next state SHALL be DONE, else WAIT_BUF.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 While pe_stall=1 in DW_RUN or PW_RUN, all counters and the col/row/rpsel outputs SHALL hold, and dwpe_ena SHALL be 0. The step SHALL be re-issued in the first cycle after pe_stall falls, so no step is skipped or duplicated.
REQ-029 pe_stall SHALL be ignored in all other states.
REQ-030 start SHALL be ignored while busy=1. Config inputs SHALL be ignored outside the start cycle.
REQ-031 buf_ready=0 in WAIT_BUF SHALL hold the state indefinitely with dwpe_ena=0.
REQ-032 col arithmetic SHALL be unsigned 28-bit with no range check against BUFW.
REQ-033 dwpe_ena SHALL be 1 only in DW_RUN and PW_RUN with pe_stall=0.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE and all outputs SHALL be 0, bank included; the block counter and captured config SHALL be 0.
REQ-035 Assertion of rst_n mid-job SHALL abort the job immediately, with no done and no blkend. The first start after release SHALL begin with bank=0.

Verification
REQ-036 dw_mode=1, nblk=1, tiles=2, buf_ready=1: the bench SHALL see 18 dwpe_ena cycles with (row,col) from (0,0),(0,1),(0,2),(1,0) through (2,2), then (0,32) through (2,34); then blkend for one cycle, done on the following cycle, and bank=1.
REQ-037 dw_mode=0, nblk=2, buf_ready=1: the bench SHALL see 144 dwpe_ena cycles per block with rpsel cycling 0,1,2 per col 0..47; blkend twice; bank 0 then 1 then 0; one done.
REQ-038 pe_stall high for 3 cycles at DW step (1,1): the bench SHALL see outputs held, dwpe_ena=0 for 3 cycles, the step (1,1) re-issued once, and a total of 9+3 cycles before blkend.
REQ-039 buf_ready low for 10 cycles after start: the bench SHALL see busy=1 with no dwpe_ena. The first valid step SHALL come 1 cycle after buf_ready rises.
REQ-040 start with nblk=0: the bench SHALL see done on the 2nd cycle after start, with no dwpe_ena or blkend. A second start pulsed during a busy job SHALL be ignored.
REQ-041 rst_n dropped mid-DW_RUN: all outputs SHALL be 0 asynchronously. After release, a new job SHALL start from bank=0, row=0, col=0.
